// File: rtl/sim_aximm_rd_arbiter.sv
// Two-requester AXI4 read arbiter: round-robin grant, one burst in flight,
// R beats routed combinationally to the granted requester with beat/RID error flagging.
module sim_aximm_rd_arbiter #(
    parameter int C_M00_AXI_ADDR_WIDTH = 32,
    parameter int C_M00_AXI_DATA_WIDTH = 32,
    parameter int C_M00_AXI_ID_WIDTH   = 1
) (
    input  logic                            m00_axi_aclk,
    input  logic                            m00_axi_areset,

    input  logic                            req0_valid,
    input  logic [C_M00_AXI_ADDR_WIDTH-1:0] req0_addr,
    input  logic [7:0]                      req0_len,
    output logic                            req0_ack,
    output logic [C_M00_AXI_DATA_WIDTH-1:0] req0_rdata,
    output logic [1:0]                      req0_rresp,
    output logic                            req0_rvalid,
    output logic                            req0_rlast,

    input  logic                            req1_valid,
    input  logic [C_M00_AXI_ADDR_WIDTH-1:0] req1_addr,
    input  logic [7:0]                      req1_len,
    output logic                            req1_ack,
    output logic [C_M00_AXI_DATA_WIDTH-1:0] req1_rdata,
    output logic [1:0]                      req1_rresp,
    output logic                            req1_rvalid,
    output logic                            req1_rlast,

    output logic [C_M00_AXI_ID_WIDTH-1:0]   m00_axi_arid,
    output logic [C_M00_AXI_ADDR_WIDTH-1:0] m00_axi_araddr,
    output logic [7:0]                      m00_axi_arlen,
    output logic [2:0]                      m00_axi_arsize,
    output logic [1:0]                      m00_axi_arburst,
    output logic                            m00_axi_arlock,
    output logic [3:0]                      m00_axi_arcache,
    output logic [2:0]                      m00_axi_arprot,
    output logic [3:0]                      m00_axi_arqos,
    output logic                            m00_axi_arvalid,
    input  logic                            m00_axi_arready,

    input  logic [C_M00_AXI_ID_WIDTH-1:0]   m00_axi_rid,
    input  logic [C_M00_AXI_DATA_WIDTH-1:0] m00_axi_rdata,
    input  logic [1:0]                      m00_axi_rresp,
    input  logic                            m00_axi_rlast,
    input  logic                            m00_axi_rvalid,
    output logic                            m00_axi_rready,

    output logic                            err
);

    localparam logic [2:0] AR_SIZE = 3'($clog2(C_M00_AXI_DATA_WIDTH / 8));

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t                          state_q, state_d;
    logic                            grant_q, grant_d;
    logic                            last_grant_q, last_grant_d;
    logic [C_M00_AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]                      len_q, len_d;
    logic [7:0]                      beat_cnt_q, beat_cnt_d;

    logic [1:0]                      req_valid;
    logic [1:0]                      ack_vec;
    logic                            win;
    logic                            err_raw;
    logic [C_M00_AXI_ID_WIDTH-1:0]   grant_id;
    logic                            in_addr;
    logic                            in_data;
    logic                            beat_fire;
    logic [1:0]                      ack_o;
    logic [1:0]                      rvalid_o;
    logic [1:0]                      rlast_o;

    assign req_valid = {req1_valid, req0_valid};

    always_comb begin
        grant_id    = '0;
        grant_id[0] = grant_q;
    end

    // Every handshake-facing output is forced low while reset is held,
    // even though the state register only clears at the edge.
    assign in_addr   = (state_q == ST_ADDR) && !m00_axi_areset;
    assign in_data   = (state_q == ST_DATA) && !m00_axi_areset;
    assign beat_fire = in_data && m00_axi_rvalid;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        len_d        = len_q;
        beat_cnt_d   = beat_cnt_q;
        ack_vec      = 2'b00;
        win          = 1'b0;
        err_raw      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    win          = (&req_valid) ? ~last_grant_q : req_valid[1];
                    grant_d      = win;
                    addr_d       = win ? req1_addr : req0_addr;
                    len_d        = win ? req1_len : req0_len;
                    ack_vec[win] = 1'b1;
                    state_d      = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (m00_axi_arready) begin
                    beat_cnt_d = 8'd0;
                    state_d    = ST_DATA;
                end
            end
            ST_DATA: begin
                if (m00_axi_rvalid) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    // beat_cnt_q is the index of the current beat; the final one is index len
                    if (m00_axi_rlast && (beat_cnt_q != len_q)) begin
                        err_raw = 1'b1;
                    end
                    if (!m00_axi_rlast && (beat_cnt_q == len_q)) begin
                        err_raw = 1'b1;
                    end
                    if (m00_axi_rid != grant_id) begin
                        err_raw = 1'b1;
                    end
                    if (m00_axi_rlast) begin
                        last_grant_d = grant_q;
                        state_d      = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge m00_axi_aclk) begin
        if (m00_axi_areset) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            len_q        <= 8'd0;
            beat_cnt_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        assign ack_o[gi]    = ack_vec[gi] && !m00_axi_areset;
        assign rvalid_o[gi] = beat_fire && (grant_q == 1'(gi));
        assign rlast_o[gi]  = beat_fire && m00_axi_rlast && (grant_q == 1'(gi));
    end

    assign req0_ack    = ack_o[0];
    assign req1_ack    = ack_o[1];
    assign req0_rvalid = rvalid_o[0];
    assign req1_rvalid = rvalid_o[1];
    assign req0_rlast  = rlast_o[0];
    assign req1_rlast  = rlast_o[1];
    assign req0_rdata  = m00_axi_rdata;
    assign req1_rdata  = m00_axi_rdata;
    assign req0_rresp  = m00_axi_rresp;
    assign req1_rresp  = m00_axi_rresp;

    assign m00_axi_arvalid = in_addr;
    assign m00_axi_arid    = grant_id;
    assign m00_axi_araddr  = addr_q;
    assign m00_axi_arlen   = len_q;
    assign m00_axi_arsize  = AR_SIZE;
    assign m00_axi_arburst = 2'b01;
    assign m00_axi_arlock  = 1'b0;
    assign m00_axi_arcache = 4'b0011;
    assign m00_axi_arprot  = 3'b000;
    assign m00_axi_arqos   = 4'b0000;
    assign m00_axi_rready  = in_data;

    assign err = beat_fire && err_raw;

endmodule

// File: tb/tb_sim_aximm_rd_arbiter.sv
// Self-checking bench for sim_aximm_rd_arbiter: directed scenarios plus randomized
// bursts, compared against a round-robin / beat-rule reference model.
module tb_sim_aximm_rd_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          req0_valid, req1_valid;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [7:0]    req0_len, req1_len;
    logic          req0_ack, req1_ack;
    logic [DW-1:0] req0_rdata, req1_rdata;
    logic [1:0]    req0_rresp, req1_rresp;
    logic          req0_rvalid, req1_rvalid, req0_rlast, req1_rlast;
    logic [IW-1:0] m_arid;
    logic [AW-1:0] m_araddr;
    logic [7:0]    m_arlen;
    logic [2:0]    m_arsize, m_arprot;
    logic [1:0]    m_arburst;
    logic          m_arlock, m_arvalid, m_arready;
    logic [3:0]    m_arcache, m_arqos;
    logic [IW-1:0] m_rid;
    logic [DW-1:0] m_rdata;
    logic [1:0]    m_rresp;
    logic          m_rlast, m_rvalid, m_rready;
    logic          err;

    sim_aximm_rd_arbiter #(
        .C_M00_AXI_ADDR_WIDTH(AW), .C_M00_AXI_DATA_WIDTH(DW), .C_M00_AXI_ID_WIDTH(IW)
    ) dut (
        .m00_axi_aclk(clk), .m00_axi_areset(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_len(req0_len), .req0_ack(req0_ack),
        .req0_rdata(req0_rdata), .req0_rresp(req0_rresp), .req0_rvalid(req0_rvalid), .req0_rlast(req0_rlast),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_len(req1_len), .req1_ack(req1_ack),
        .req1_rdata(req1_rdata), .req1_rresp(req1_rresp), .req1_rvalid(req1_rvalid), .req1_rlast(req1_rlast),
        .m00_axi_arid(m_arid), .m00_axi_araddr(m_araddr), .m00_axi_arlen(m_arlen),
        .m00_axi_arsize(m_arsize), .m00_axi_arburst(m_arburst), .m00_axi_arlock(m_arlock),
        .m00_axi_arcache(m_arcache), .m00_axi_arprot(m_arprot), .m00_axi_arqos(m_arqos),
        .m00_axi_arvalid(m_arvalid), .m00_axi_arready(m_arready),
        .m00_axi_rid(m_rid), .m00_axi_rdata(m_rdata), .m00_axi_rresp(m_rresp),
        .m00_axi_rlast(m_rlast), .m00_axi_rvalid(m_rvalid), .m00_axi_rready(m_rready),
        .err(err)
    );

    int checks = 0;
    int failures = 0;
    bit model_last = 1'b1;

    // observations gathered by drive_burst
    int            o_grant, o_extra_ack, o_ar_cycles, o_ar_unstable, o_rr_bad;
    int            o_other_bad, o_valid_bad, o_err_cnt, o_rlast_cnt, o_rlast_pos;
    bit            o_timeout, o_ack0, o_ack1, o_arv_ack, o_rr_after;
    logic [AW-1:0] o_araddr;
    logic [7:0]    o_arlen;
    logic [IW-1:0] o_arid;
    logic [2:0]    o_arsize, o_arprot;
    logic [1:0]    o_arburst;
    logic [3:0]    o_arcache, o_arqos;
    logic          o_arlock;
    logic [DW+1:0] sent_q[$];
    logic [DW+1:0] got_q[$];

    function automatic int exp_grant(bit v0, bit v1, bit last);
        if (v0 && v1) return last ? 0 : 1;
        return v1 ? 1 : 0;
    endfunction

    // err fires per beat: rlast off index len, index len without rlast, or foreign id
    function automatic int exp_errs(int len, int last_idx, bit bad_rid);
        int n = 0;
        for (int i = 0; i <= last_idx; i++) begin
            if (((i == last_idx) && (i != len)) || ((i != last_idx) && (i == len)) || bad_rid) n++;
        end
        return n;
    endfunction

    task automatic clear_inputs();
        req0_valid = 0; req1_valid = 0; req0_addr = '0; req1_addr = '0; req0_len = 0; req1_len = 0;
        m_arready = 0; m_rid = '0; m_rdata = '0; m_rresp = 0; m_rlast = 0; m_rvalid = 0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_last = 1'b1;
    endtask

    task automatic drive_burst(input bit v0, input bit v1, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                               input logic [7:0] l0, input logic [7:0] l1, input int ar_wait,
                               input int gap_mode, input int last_in, input bit bad_rid, input bit keep);
        int g, li, beat;
        bit hs, rv, tog, done, first;
        logic gv, glast, ov;
        logic [IW-1:0] gid;
        o_timeout = 0; o_extra_ack = 0; o_ar_cycles = 0; o_ar_unstable = 0; o_rr_bad = 0;
        o_other_bad = 0; o_valid_bad = 0; o_err_cnt = 0; o_rlast_cnt = 0; o_rlast_pos = -1;
        o_rr_after = 1'b1;
        sent_q.delete(); got_q.delete();
        req0_valid = v0; req1_valid = v1; req0_addr = a0; req1_addr = a1; req0_len = l0; req1_len = l1;
        #1;
        o_ack0 = req0_ack; o_ack1 = req1_ack; o_arv_ack = m_arvalid;
        o_rr_bad += int'(m_rready);
        o_err_cnt += int'(err);
        g = req0_ack ? 0 : (req1_ack ? 1 : -1);
        o_grant = g;
        @(posedge clk); #1;
        if (!keep) begin req0_valid = 0; req1_valid = 0; end
        if (g < 0) begin o_timeout = 1; return; end
        li = (last_in >= 0) ? last_in : int'((g == 1) ? l1 : l0);
        gid = IW'(g);
        hs = 0; first = 1;
        for (int c = 0; c < 64 && !hs; c++) begin
            m_arready = (c >= ar_wait);
            #1;
            if (m_arvalid) begin
                if (first) begin
                    o_araddr = m_araddr; o_arlen = m_arlen; o_arid = m_arid; o_arsize = m_arsize;
                    o_arburst = m_arburst; o_arcache = m_arcache; o_arlock = m_arlock;
                    o_arprot = m_arprot; o_arqos = m_arqos; first = 0;
                end else if (m_araddr !== o_araddr || m_arlen !== o_arlen) begin
                    o_ar_unstable++;
                end
                o_ar_cycles++;
                hs = m_arready;
            end
            o_extra_ack += int'(req0_ack) + int'(req1_ack);
            o_rr_bad += int'(m_rready);
            o_err_cnt += int'(err);
            @(posedge clk); #1;
        end
        m_arready = 0;
        if (!hs) begin o_timeout = 1; return; end
        beat = 0; done = 0; tog = 1;
        for (int c = 0; c < 1024 && !done; c++) begin
            case (gap_mode)
                0: rv = 1'b1;
                1: begin rv = tog; tog = ~tog; end
                default: rv = 1'($urandom_range(0, 1));
            endcase
            m_rvalid = rv; m_rid = bad_rid ? ~gid : gid;
            m_rdata = $urandom; m_rresp = 2'($urandom_range(0, 3));
            m_rlast = rv && (beat == li);
            #1;
            if (!m_rready) o_rr_bad++;
            gv    = (g == 1) ? req1_rvalid : req0_rvalid;
            glast = (g == 1) ? req1_rlast : req0_rlast;
            ov    = (g == 1) ? (req0_rvalid | req0_rlast) : (req1_rvalid | req1_rlast);
            if (gv !== rv) o_valid_bad++;
            if (ov !== 1'b0) o_other_bad++;
            o_extra_ack += int'(req0_ack) + int'(req1_ack);
            o_err_cnt += int'(err);
            if (rv) begin
                sent_q.push_back({m_rresp, m_rdata});
                if (gv) got_q.push_back((g == 1) ? {req1_rresp, req1_rdata} : {req0_rresp, req0_rdata});
                if (glast) begin o_rlast_cnt++; o_rlast_pos = beat; end
                if (beat == li) done = 1;
                beat++;
            end else if (glast) begin
                o_rlast_cnt++;
            end
            @(posedge clk); #1;
        end
        m_rvalid = 0; m_rlast = 0;
        if (!done) o_timeout = 1;
        #1;
        o_rr_after = m_rready;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        req0_valid = 1; req1_valid = 1; m_arready = 1; m_rvalid = 1; m_rlast = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            checks++;
            if ({req0_ack, req1_ack, m_arvalid, m_rready, err, req0_rvalid, req1_rvalid, req0_rlast, req1_rlast} !== 9'd0) begin
                failures++;
                $display("FAIL reset_outputs cycle=%0d got=%b exp=0", i,
                         {req0_ack, req1_ack, m_arvalid, m_rready, err, req0_rvalid, req1_rvalid, req0_rlast, req1_rlast});
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        clear_inputs();
        model_last = 1'b1;
        #1;
        checks++;
        if ({m_arvalid, m_rready, err, req0_ack, req1_ack} !== 5'd0) begin
            failures++;
            $display("FAIL after_reset_idle got=%b exp=0", {m_arvalid, m_rready, err, req0_ack, req1_ack});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_burst();
        drive_burst(1, 0, 32'h1000, '0, 8'd3, 8'd0, 0, 0, -1, 0, 0);
        checks++; if (o_timeout) begin failures++; $display("FAIL single_timeout got=1 exp=0"); end
        checks++; if ({o_ack1, o_ack0} !== 2'b01) begin failures++; $display("FAIL single_ack got=%b exp=01", {o_ack1, o_ack0}); end
        checks++; if (o_arv_ack !== 1'b0) begin failures++; $display("FAIL single_arvalid_in_idle got=%b exp=0", o_arv_ack); end
        checks++; if (o_araddr !== 32'h1000) begin failures++; $display("FAIL single_araddr got=%h exp=1000", o_araddr); end
        checks++; if (o_arlen !== 8'd3) begin failures++; $display("FAIL single_arlen got=%0d exp=3", o_arlen); end
        checks++; if (o_arsize !== 3'd2) begin failures++; $display("FAIL single_arsize got=%0d exp=2", o_arsize); end
        checks++; if (o_arburst !== 2'b01) begin failures++; $display("FAIL single_arburst got=%0d exp=1", o_arburst); end
        checks++; if (o_arid !== 1'b0) begin failures++; $display("FAIL single_arid got=%0d exp=0", o_arid); end
        checks++;
        if ({o_arcache, o_arlock, o_arprot, o_arqos} !== {4'b0011, 1'b0, 3'd0, 4'd0}) begin
            failures++; $display("FAIL single_ar_const got=%h exp=%h", {o_arcache, o_arlock, o_arprot, o_arqos}, {4'b0011, 8'd0});
        end
        checks++; if (o_ar_cycles != 1) begin failures++; $display("FAIL single_ar_cycles got=%0d exp=1", o_ar_cycles); end
        checks++; if (got_q.size() != 4) begin failures++; $display("FAIL single_beats got=%0d exp=4", got_q.size()); end
        foreach (sent_q[i]) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== sent_q[i]) begin failures++; $display("FAIL single_data beat=%0d exp=%h", i, sent_q[i]); end
        end
        checks++; if (o_rlast_cnt != 1 || o_rlast_pos != 3) begin failures++; $display("FAIL single_rlast got cnt=%0d pos=%0d exp cnt=1 pos=3", o_rlast_cnt, o_rlast_pos); end
        checks++; if (o_err_cnt != 0) begin failures++; $display("FAIL single_err got=%0d exp=0", o_err_cnt); end
        checks++; if (o_other_bad != 0 || o_valid_bad != 0 || o_rr_bad != 0 || o_extra_ack != 0) begin
            failures++; $display("FAIL single_routing got other=%0d valid=%0d rready=%0d acks=%0d exp=0", o_other_bad, o_valid_bad, o_rr_bad, o_extra_ack);
        end
        checks++; if (o_rr_after !== 1'b0) begin failures++; $display("FAIL single_idle_after got=%b exp=0", o_rr_after); end
        model_last = 1'b0;
    endtask

    task automatic test_contention();
        int exp;
        logic [AW-1:0] a0, a1;
        logic [7:0] l0, l1;
        apply_reset();
        a0 = $urandom; a1 = $urandom; l0 = 8'($urandom_range(0, 5)); l1 = 8'($urandom_range(0, 5));
        for (int k = 0; k < 4; k++) begin
            exp = exp_grant(1, 1, model_last);
            drive_burst(1, 1, a0, a1, l0, l1, 0, 0, -1, 0, 1);
            checks++;
            if (o_timeout || o_grant != exp) begin failures++; $display("FAIL contention_grant burst=%0d got=%0d exp=%0d", k, o_grant, exp); end
            checks++;
            if (o_araddr !== ((exp == 1) ? a1 : a0) || o_arid !== IW'(exp)) begin
                failures++; $display("FAIL contention_ar burst=%0d got addr=%h id=%0d", k, o_araddr, o_arid);
            end
            checks++;
            if (o_extra_ack != 0 || o_err_cnt != 0) begin failures++; $display("FAIL contention_held burst=%0d got acks=%0d err=%0d exp=0", k, o_extra_ack, o_err_cnt); end
            model_last = exp[0];
        end
        req0_valid = 0; req1_valid = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int exp;
        exp = exp_grant(0, 1, model_last);
        drive_burst(0, 1, '0, 32'hABCD_0040, 8'd0, 8'd2, 5, 0, -1, 0, 0);
        checks++; if (o_timeout || o_grant != exp) begin failures++; $display("FAIL bp_grant got=%0d exp=%0d", o_grant, exp); end
        checks++; if (o_ar_cycles != 6) begin failures++; $display("FAIL bp_ar_cycles got=%0d exp=6", o_ar_cycles); end
        checks++; if (o_ar_unstable != 0) begin failures++; $display("FAIL bp_ar_stable got=%0d exp=0", o_ar_unstable); end
        checks++; if (o_araddr !== 32'hABCD_0040 || o_arlen !== 8'd2) begin failures++; $display("FAIL bp_ar_fields got=%h/%0d exp=abcd0040/2", o_araddr, o_arlen); end
        checks++; if (o_rr_bad != 0 || got_q.size() != 3) begin failures++; $display("FAIL bp_data got rready_bad=%0d beats=%0d exp 0/3", o_rr_bad, got_q.size()); end
        model_last = exp[0];
    endtask

    task automatic test_gapped();
        int exp;
        exp = exp_grant(1, 0, model_last);
        drive_burst(1, 0, 32'h0000_8000, '0, 8'd7, 8'd0, 0, 1, -1, 0, 0);
        checks++; if (o_timeout || o_grant != exp) begin failures++; $display("FAIL gapped_grant got=%0d exp=%0d", o_grant, exp); end
        checks++; if (got_q.size() != 8) begin failures++; $display("FAIL gapped_beats got=%0d exp=8", got_q.size()); end
        foreach (sent_q[i]) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== sent_q[i]) begin failures++; $display("FAIL gapped_data beat=%0d exp=%h", i, sent_q[i]); end
        end
        checks++; if (o_valid_bad != 0) begin failures++; $display("FAIL gapped_rvalid_follow got=%0d exp=0", o_valid_bad); end
        checks++; if (o_rlast_cnt != 1 || o_rlast_pos != 7) begin failures++; $display("FAIL gapped_rlast got cnt=%0d pos=%0d exp 1/7", o_rlast_cnt, o_rlast_pos); end
        checks++; if (o_err_cnt != 0) begin failures++; $display("FAIL gapped_err got=%0d exp=0", o_err_cnt); end
        model_last = exp[0];
    endtask

    task automatic test_errors();
        int exp;
        // early rlast on the second beat of a 4-beat burst
        drive_burst(1, 0, 32'h100, '0, 8'd3, 8'd0, 0, 0, 1, 0, 0);
        exp = exp_errs(3, 1, 0);
        checks++; if (o_timeout || o_err_cnt != exp) begin failures++; $display("FAIL err_early_rlast got=%0d exp=%0d", o_err_cnt, exp); end
        checks++; if (o_rr_after !== 1'b0) begin failures++; $display("FAIL err_early_idle got rready=%b exp=0", o_rr_after); end
        model_last = 1'b0;
        // foreign RID on every beat
        drive_burst(1, 0, 32'h200, '0, 8'd2, 8'd0, 0, 0, -1, 1, 0);
        exp = exp_errs(2, 2, 1);
        checks++; if (o_timeout || o_grant != 0 || o_err_cnt != exp) begin failures++; $display("FAIL err_rid got=%0d exp=%0d", o_err_cnt, exp); end
        // rlast arrives two beats late: one err at index len, one on the late rlast
        drive_burst(0, 1, '0, 32'h300, 8'd0, 8'd1, 0, 0, 3, 0, 0);
        exp = exp_errs(1, 3, 0);
        checks++; if (o_timeout || o_grant != 1 || o_err_cnt != exp) begin failures++; $display("FAIL err_late_rlast got=%0d exp=%0d", o_err_cnt, exp); end
        checks++; if (got_q.size() != 4 || o_rlast_pos != 3) begin failures++; $display("FAIL err_late_beats got=%0d pos=%0d exp 4/3", got_q.size(), o_rlast_pos); end
        model_last = 1'b1;
    endtask

    task automatic test_reset_mid_data();
        logic [DW-1:0] d;
        req0_valid = 1; req0_addr = 32'h2000; req0_len = 8'd7;
        #1;
        checks++; if (req0_ack !== 1'b1) begin failures++; $display("FAIL rmd_ack got=%b exp=1", req0_ack); end
        @(posedge clk); #1;
        req0_valid = 0; m_arready = 1;
        #1;
        checks++; if (m_arvalid !== 1'b1) begin failures++; $display("FAIL rmd_arvalid got=%b exp=1", m_arvalid); end
        @(posedge clk); #1;
        m_arready = 0;
        for (int i = 0; i < 2; i++) begin
            d = $urandom;
            m_rvalid = 1; m_rid = '0; m_rdata = d; m_rlast = 0;
            #1;
            checks++; if (req0_rvalid !== 1'b1 || req0_rdata !== d) begin failures++; $display("FAIL rmd_beat%0d got v=%b d=%h exp v=1 d=%h", i, req0_rvalid, req0_rdata, d); end
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        checks++; if ({m_rready, req0_rvalid} !== 2'b00) begin failures++; $display("FAIL rmd_during_reset got=%b exp=00", {m_rready, req0_rvalid}); end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++; if ({m_rready, req0_rvalid, m_arvalid, err} !== 4'b0000) begin failures++; $display("FAIL rmd_after_reset got=%b exp=0000", {m_rready, req0_rvalid, m_arvalid, err}); end
        m_rvalid = 0;
        model_last = 1'b1;
        drive_burst(0, 1, '0, 32'h3000, 8'd0, 8'd3, 0, 0, -1, 0, 0);
        checks++; if (o_timeout || o_grant != 1 || o_arid !== 1'b1) begin failures++; $display("FAIL rmd_new_grant got=%0d id=%0d exp=1", o_grant, o_arid); end
        checks++; if (got_q.size() != 4 || o_err_cnt != 0 || o_rlast_pos != 3) begin
            failures++; $display("FAIL rmd_new_burst got beats=%0d err=%0d pos=%0d exp 4/0/3", got_q.size(), o_err_cnt, o_rlast_pos);
        end
        model_last = 1'b1;
    endtask

    task automatic test_random();
        bit v0, v1;
        int exp;
        logic [AW-1:0] a0, a1;
        logic [7:0] l0, l1;
        for (int n = 0; n < 20; n++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            a0 = $urandom; a1 = $urandom;
            l0 = 8'($urandom_range(0, 15)); l1 = 8'($urandom_range(0, 15));
            exp = exp_grant(v0, v1, model_last);
            drive_burst(v0, v1, a0, a1, l0, l1, $urandom_range(0, 3), $urandom_range(0, 2), -1, 0, 0);
            checks++;
            if (o_timeout || o_grant != exp) begin failures++; $display("FAIL rand_grant n=%0d got=%0d exp=%0d", n, o_grant, exp); end
            checks++;
            if (o_araddr !== ((exp == 1) ? a1 : a0) || o_arlen !== ((exp == 1) ? l1 : l0) || o_arid !== IW'(exp)) begin
                failures++; $display("FAIL rand_ar n=%0d got addr=%h len=%0d id=%0d", n, o_araddr, o_arlen, o_arid);
            end
            checks++;
            if (got_q.size() != sent_q.size() || got_q.size() != int'((exp == 1) ? l1 : l0) + 1) begin
                failures++; $display("FAIL rand_beats n=%0d got=%0d sent=%0d", n, got_q.size(), sent_q.size());
            end
            foreach (sent_q[i]) begin
                checks++;
                if (i >= got_q.size() || got_q[i] !== sent_q[i]) begin failures++; $display("FAIL rand_data n=%0d beat=%0d exp=%h", n, i, sent_q[i]); end
            end
            checks++;
            if (o_err_cnt != 0 || o_rlast_cnt != 1 || o_other_bad != 0 || o_valid_bad != 0 || o_rr_bad != 0 || o_extra_ack != 0) begin
                failures++; $display("FAIL rand_protocol n=%0d got err=%0d rlast=%0d other=%0d valid=%0d rready=%0d acks=%0d",
                                     n, o_err_cnt, o_rlast_cnt, o_other_bad, o_valid_bad, o_rr_bad, o_extra_ack);
            end
            model_last = exp[0];
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_burst();
        test_contention();
        test_backpressure();
        test_gapped();
        test_errors();
        test_reset_mid_data();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
